output_buffer: RTL and testbench

OUTPUT_BUFFER -- requirements
Module: output_buffer

---
 rtl/output_buffer.sv | 170 +++++++++++++++++
 tb/tb_output_buffer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/output_buffer.sv
// rtl/output_buffer.sv - memory-mapped LED/HEX/LCD output registers; OUTPUT_BUFFER_HEXDEC_EN enables the HEX nibble decoder
module output_buffer #(
    parameter logic [15:0] BASE_ADDR = 16'h7000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_addr,
    input  logic        i_st_en,
    input  logic [1:0]  i_st_size,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [55:0] o_io_hex,
    output logic [31:0] o_io_lcd,
    output logic        o_misalign
);

    logic [31:0] ledr_q, ledr_d;
    logic [31:0] ledg_q, ledg_d;
    logic [31:0] hexlo_q, hexlo_d;
    logic [31:0] hexhi_q, hexhi_d;
    logic [31:0] lcd_q, lcd_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        misalign_q, misalign_d;

    logic [15:0] offset;
    logic        sel_ledr, sel_ledg, sel_hexlo, sel_hexhi, sel_lcd, mapped;
    logic [1:0]  lane;
    logic [3:0]  byte_en;
    logic        legal;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] rdata;

    // Offsets below BASE_ADDR wrap to large values and fall out of every range.
    assign offset    = i_addr - BASE_ADDR;
    assign sel_ledr  = (offset[15:4] == 12'h000);
    assign sel_ledg  = (offset[15:4] == 12'h001);
    assign sel_hexlo = (offset[15:2] == 14'h0008);
    assign sel_hexhi = (offset[15:2] == 14'h0009);
    assign sel_lcd   = (offset[15:4] == 12'h003);
    assign mapped    = sel_ledr | sel_ledg | sel_hexlo | sel_hexhi | sel_lcd;
    assign lane      = i_addr[1:0];

    always_comb begin
        byte_en = 4'b0000;
        legal   = 1'b0;
        wdata   = i_st_data;
        case (i_st_size)
            2'b00: begin
                legal   = 1'b1;
                byte_en = 4'b0001 << lane;
                wdata   = {4{i_st_data[7:0]}};
            end
            2'b01: begin
                legal   = ~lane[0];
                byte_en = 4'b0011 << lane;
                wdata   = {2{i_st_data[15:0]}};
            end
            2'b10: begin
                legal   = (lane == 2'b00);
                byte_en = 4'b1111;
            end
            default: begin
                legal   = 1'b0;
                byte_en = 4'b0000;
            end
        endcase
    end

    assign wr = i_st_en & mapped & legal;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] wd);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
        return res;
    endfunction

    always_comb begin
        rdata = 32'h0;
        if (sel_ledr)  rdata = ledr_q;
        if (sel_ledg)  rdata = ledg_q;
        if (sel_hexlo) rdata = hexlo_q;
        if (sel_hexhi) rdata = hexhi_q;
        if (sel_lcd)   rdata = lcd_q;
    end

    // Readback samples the pre-write register, so a same-cycle store is not forwarded.
    always_comb begin
        ledr_d     = (wr && sel_ledr)  ? merge(ledr_q,  byte_en, wdata) : ledr_q;
        ledg_d     = (wr && sel_ledg)  ? merge(ledg_q,  byte_en, wdata) : ledg_q;
        hexlo_d    = (wr && sel_hexlo) ? merge(hexlo_q, byte_en, wdata) : hexlo_q;
        hexhi_d    = (wr && sel_hexhi) ? merge(hexhi_q, byte_en, wdata) : hexhi_q;
        lcd_d      = (wr && sel_lcd)   ? merge(lcd_q,   byte_en, wdata) : lcd_q;
        ld_data_d  = rdata;
        misalign_d = i_st_en & mapped & ~legal;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ledr_q     <= 32'h0;
            ledg_q     <= 32'h0;
            hexlo_q    <= 32'h0;
            hexhi_q    <= 32'h0;
            lcd_q      <= 32'h0;
            ld_data_q  <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            ledr_q     <= ledr_d;
            ledg_q     <= ledg_d;
            hexlo_q    <= hexlo_d;
            hexhi_q    <= hexhi_d;
            lcd_q      <= lcd_d;
            ld_data_q  <= ld_data_d;
            misalign_q <= misalign_d;
        end
    end

    assign o_ld_data  = ld_data_q;
    assign o_io_ledr  = ledr_q;
    assign o_io_ledg  = ledg_q;
    assign o_io_lcd   = lcd_q;
    assign o_misalign = misalign_q;

`ifdef OUTPUT_BUFFER_HEXDEC_EN
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Reset registers hold 0, which decodes to the "0" glyph on every digit.
    always_comb begin
        o_io_hex = 56'h0;
        for (int n = 0; n < 4; n++) begin
            o_io_hex[7*n +: 7]     = seg7(hexlo_q[8*n +: 4]);
            o_io_hex[7*(n+4) +: 7] = seg7(hexhi_q[8*n +: 4]);
        end
    end
`else
    always_comb begin
        o_io_hex = 56'h0;
        for (int n = 0; n < 4; n++) begin
            o_io_hex[7*n +: 7]     = hexlo_q[8*n +: 7];
            o_io_hex[7*(n+4) +: 7] = hexhi_q[8*n +: 7];
        end
    end
`endif

endmodule

// File: tb/tb_output_buffer.sv
// tb/tb_output_buffer.sv - directed and randomized checks of output_buffer against a byte-level model
module tb_output_buffer;

    localparam logic [15:0] BASE = 16'h7000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic        st_en;
    logic [1:0]  st_size;
    logic [31:0] st_data;
    logic [31:0] ld_data, ledr, ledg, lcd;
    logic [55:0] hex;
    logic        misalign;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m [5];
    logic [31:0] exp_ld;
    logic        exp_mis;
    logic [6:0]  seg_tbl [16];

    always #5 clk = ~clk;

    output_buffer #(.BASE_ADDR(BASE)) dut (
        .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_st_en(st_en),
        .i_st_size(st_size), .i_st_data(st_data), .o_ld_data(ld_data),
        .o_io_ledr(ledr), .o_io_ledg(ledg), .o_io_hex(hex), .o_io_lcd(lcd),
        .o_misalign(misalign)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int reg_idx(input logic [15:0] a);
        int off;
        off = int'(a) - int'(BASE);
        if (off >= 0 && off < 16) return 0;
        if (off >= 16 && off < 32) return 1;
        if (off >= 32 && off < 36) return 2;
        if (off >= 36 && off < 40) return 3;
        if (off >= 48 && off < 64) return 4;
        return -1;
    endfunction

    function automatic logic [55:0] exp_hex();
        logic [55:0] h;
        logic [7:0]  b;
        h = '0;
        for (int n = 0; n < 8; n++) begin
            b = (n < 4) ? m[2][8*n +: 8] : m[3][8*(n-4) +: 8];
`ifdef OUTPUT_BUFFER_HEXDEC_EN
            h[7*n +: 7] = seg_tbl[b[3:0]];
`else
            h[7*n +: 7] = b[6:0];
`endif
        end
        return h;
    endfunction

    // One clock: update the model from the rules, then compare every output.
    task automatic step(input logic [15:0] a, input logic en, input logic [1:0] sz,
                        input logic [31:0] d, input logic r);
        int idx, nb, start;
        logic ok;
        idx = reg_idx(a);
        ok  = (sz == 2'd0) || (sz == 2'd1 && a[0] == 1'b0) || (sz == 2'd2 && a[1:0] == 2'd0);
        exp_ld  = (r || idx < 0) ? 32'h0 : m[idx];
        exp_mis = !r && en && idx >= 0 && !ok;
        if (r) begin
            for (int i = 0; i < 5; i++) m[i] = 32'h0;
        end else if (en && idx >= 0 && ok) begin
            nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            start = (sz == 2'd2) ? 0 : int'(a[1:0]);
            for (int k = 0; k < nb; k++) m[idx][8*(start+k) +: 8] = d[8*k +: 8];
        end
        addr = a; st_en = en; st_size = sz; st_data = d; rst = r;
        @(posedge clk);
        #1;
        chk("ld_data", {32'h0, ld_data}, {32'h0, exp_ld});
        chk("misalign", {63'h0, misalign}, {63'h0, exp_mis});
        chk("ledr", {32'h0, ledr}, {32'h0, m[0]});
        chk("ledg", {32'h0, ledg}, {32'h0, m[1]});
        chk("lcd", {32'h0, lcd}, {32'h0, m[4]});
        chk("hex", {8'h0, hex}, {8'h0, exp_hex()});
    endtask

    initial begin
        logic [15:0] ra;
        seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        for (int i = 0; i < 5; i++) m[i] = 32'h0;
        addr = '0; st_en = 0; st_size = 0; st_data = 0; rst = 1;

        step(16'h7000, 1'b0, 2'd0, 32'h0, 1'b1);
        step(16'h7000, 1'b0, 2'd0, 32'h0, 1'b1);
`ifdef OUTPUT_BUFFER_HEXDEC_EN
        chk("reset_hex", {8'h0, hex}, {8'h0, {8{7'h40}}});
`else
        chk("reset_hex", {8'h0, hex}, 64'h0);
`endif

        step(16'h7000, 1'b1, 2'd2, 32'hDEADBEEF, 1'b0);
        chk("ledr_word", {32'h0, ledr}, 64'hDEADBEEF);
        step(16'h7004, 1'b0, 2'd0, 32'h0, 1'b0);
        chk("ledr_alias_read", {32'h0, ld_data}, 64'hDEADBEEF);

        step(16'h7010, 1'b1, 2'd2, 32'h0, 1'b0);
        step(16'h7012, 1'b1, 2'd0, 32'h000000A5, 1'b0);
        chk("ledg_byte", {32'h0, ledg}, 64'h00A50000);
        step(16'h7010, 1'b1, 2'd1, 32'h00001234, 1'b0);
        chk("ledg_half", {32'h0, ledg}, 64'h00A51234);

        step(16'h7001, 1'b1, 2'd1, 32'hFFFFFFFF, 1'b0);
        chk("mis_half_flag", {63'h0, misalign}, 64'h1);
        chk("mis_half_ledr", {32'h0, ledr}, 64'hDEADBEEF);
        step(16'h7000, 1'b0, 2'd0, 32'h0, 1'b0);
        chk("mis_pulse_end", {63'h0, misalign}, 64'h0);
        step(16'h7022, 1'b1, 2'd2, 32'hFFFFFFFF, 1'b0);
        chk("mis_word_flag", {63'h0, misalign}, 64'h1);
        step(16'h7080, 1'b1, 2'd2, 32'hFFFFFFFF, 1'b0);
        chk("unmapped_noflag", {63'h0, misalign}, 64'h0);

        step(16'h7020, 1'b1, 2'd2, 32'h0F080100, 1'b0);
`ifdef OUTPUT_BUFFER_HEXDEC_EN
        chk("hex0", {57'h0, hex[6:0]}, 64'h40);
        chk("hex3", {57'h0, hex[27:21]}, 64'h0E);
`else
        chk("hex0", {57'h0, hex[6:0]}, 64'h00);
        chk("hex3", {57'h0, hex[27:21]}, 64'h0F);
`endif

        step(16'h7030, 1'b1, 2'd2, 32'h0, 1'b0);
        step(16'h7030, 1'b1, 2'd2, 32'h80000155, 1'b0);
        chk("lcd_rw_old", {32'h0, ld_data}, 64'h0);
        step(16'h7030, 1'b0, 2'd0, 32'h0, 1'b0);
        chk("lcd_rw_new", {32'h0, ld_data}, 64'h80000155);

        step(16'h7000, 1'b1, 2'd2, 32'h12345678, 1'b1);
        chk("rst_ledr", {32'h0, ledr}, 64'h0);
        step(16'h7000, 1'b1, 2'd2, 32'h12345678, 1'b0);
        chk("post_rst_store", {32'h0, ledr}, 64'h12345678);

        for (int i = 0; i < 400; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 16'($urandom) : BASE + 16'($urandom_range(0, 16'h4F));
            step(ra, 1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom,
                 1'($urandom_range(0, 60) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
